// File: rtl/mode_dispatcher.sv
// Top-level piano mode sequencer: menu/song-select/run/learn FSM, system tick,
// transactional key-remap table and per-mode board output multiplexing.
module mode_dispatcher #(
    parameter int KEY_BITS      = 7,
    parameter int N_MODES       = 4,
    parameter int SONG_BITS     = 2,
    parameter int N_SONGS       = 3,
    parameter int TUBE_BITS     = 8,
    parameter int TICK_DIV      = 100000,
    parameter int CLOCK_BITS    = 32,
    parameter int LEARN_TIMEOUT = 50
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           submit,
    input  logic                           cancel,
    input  logic [KEY_BITS-1:0]            note_key,
    input  logic [N_MODES-1:0]             needs_song,
    input  logic [N_MODES-1:0]             mode_buzzer,
    input  logic [N_MODES*KEY_BITS-1:0]    mode_led,
    input  logic [N_MODES*TUBE_BITS-1:0]   mode_seg_en,
    input  logic [N_MODES*TUBE_BITS-1:0]   mode_tube1,
    input  logic [N_MODES*TUBE_BITS-1:0]   mode_tube2,
    input  logic [TUBE_BITS-1:0]           menu_seg_en,
    input  logic [TUBE_BITS-1:0]           menu_tube1,
    input  logic [TUBE_BITS-1:0]           menu_tube2,
    output logic [N_MODES-1:0]             mode_en,
    output logic [1:0]                     state,
    output logic [SONG_BITS-1:0]           song,
    output logic [KEY_BITS-1:0]            mapped_key,
    output logic                           tick,
    output logic [CLOCK_BITS-1:0]          system_clock,
    output logic                           buzzer,
    output logic [KEY_BITS-1:0]            led,
    output logic [TUBE_BITS-1:0]           seg_en,
    output logic [TUBE_BITS-1:0]           tube1,
    output logic [TUBE_BITS-1:0]           tube2,
    output logic [$clog2(KEY_BITS+1)-1:0]  learn_idx
);

    localparam int IDXW = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;
    localparam int SELW = (N_MODES > 1) ? $clog2(N_MODES) : 1;
    localparam int LIW  = $clog2(KEY_BITS + 1);
    localparam int DIVW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TOW  = $clog2(LEARN_TIMEOUT + 1);

    typedef enum logic [1:0] {
        MENU     = 2'd0,
        SONG_SEL = 2'd1,
        RUN      = 2'd2,
        LEARN    = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [SELW-1:0]       sel_q, sel_d;
    logic [SONG_BITS-1:0]  song_q, song_d;
    logic [LIW-1:0]        lidx_q, lidx_d;
    logic [TOW-1:0]        to_q, to_d;
    logic [KEY_BITS-1:0]   written_q, written_d;
    logic [KEY_BITS-1:0]   table_q  [KEY_BITS];
    logic [KEY_BITS-1:0]   table_d  [KEY_BITS];
    logic [KEY_BITS-1:0]   backup_q [KEY_BITS];
    logic [KEY_BITS-1:0]   backup_d [KEY_BITS];
    logic [DIVW-1:0]       div_q;
    logic [CLOCK_BITS-1:0] clock_q;
    logic                  sub_q, sub_qq, can_q, can_qq;
    logic                  sp, cp, key_ok;
    logic [IDXW-1:0]       key_idx;
    logic [KEY_BITS-1:0]   mapped_q, mapped_d, led_q, led_d;
    logic                  buzzer_q, buzzer_d;
    logic [TUBE_BITS-1:0]  seg_q, seg_d, t1_q, t1_d, t2_q, t2_d;

    assign tick = (div_q == DIVW'(TICK_DIV - 1));
    assign sp   = sub_q & ~sub_qq;
    assign cp   = can_q & ~can_qq;

    always_comb begin
        key_ok  = $onehot(note_key);
        key_idx = '0;
        for (int unsigned i = 0; i < KEY_BITS; i++) begin
            if (note_key[i]) key_idx = IDXW'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        song_d    = song_q;
        lidx_d    = lidx_q;
        to_d      = to_q;
        written_d = written_q;
        table_d   = table_q;
        backup_d  = backup_q;
        if (state_q == LEARN && tick) to_d = to_q + TOW'(1);
        unique case (state_q)
            MENU: begin
                if (sp && !cp && key_ok) begin
                    if (key_idx < IDXW'(N_MODES)) begin
                        sel_d   = SELW'(key_idx);
                        state_d = needs_song[SELW'(key_idx)] ? SONG_SEL : RUN;
                    end else if (key_idx == IDXW'(N_MODES)) begin
                        backup_d  = table_q;
                        lidx_d    = '0;
                        to_d      = '0;
                        written_d = '0;
                        state_d   = LEARN;
                    end
                end
            end
            SONG_SEL: begin
                if (cp) begin
                    state_d = MENU;
                    song_d  = '0;
                end else if (sp && key_ok && key_idx < IDXW'(N_SONGS)) begin
                    song_d  = SONG_BITS'(key_idx) + SONG_BITS'(1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cp) begin
                    state_d = MENU;
                    song_d  = '0;
                end
            end
            LEARN: begin
                // Entries are rewritten in place; backup holds the pre-session table.
                if (cp || to_q == TOW'(LEARN_TIMEOUT)) begin
                    table_d = backup_q;
                    state_d = MENU;
                    song_d  = '0;
                end else if (sp && key_ok && !written_q[key_idx]) begin
                    table_d[key_idx]   = KEY_BITS'(1) << lidx_q;
                    written_d[key_idx] = 1'b1;
                    lidx_d             = lidx_q + LIW'(1);
                    to_d               = '0;
                    if (lidx_q == LIW'(KEY_BITS - 1)) state_d = MENU;
                end
            end
        endcase
    end

    always_comb begin
        mapped_d = '0;
        if (state_q == SONG_SEL || state_q == RUN) begin
            for (int unsigned i = 0; i < KEY_BITS; i++) begin
                if (note_key[i]) mapped_d = mapped_d | table_q[i];
            end
        end
        buzzer_d = 1'b0;
        led_d    = '0;
        seg_d    = menu_seg_en;
        t1_d     = menu_tube1;
        t2_d     = menu_tube2;
        unique case (state_q)
            MENU: ;
            SONG_SEL: led_d = KEY_BITS'(1) << sel_q;
            RUN: begin
                buzzer_d = mode_buzzer[sel_q];
                led_d    = mode_led[int'(sel_q)*KEY_BITS +: KEY_BITS];
                seg_d    = mode_seg_en[int'(sel_q)*TUBE_BITS +: TUBE_BITS];
                t1_d     = mode_tube1[int'(sel_q)*TUBE_BITS +: TUBE_BITS];
                t2_d     = mode_tube2[int'(sel_q)*TUBE_BITS +: TUBE_BITS];
            end
            LEARN: led_d = (lidx_q < LIW'(KEY_BITS)) ? (KEY_BITS'(1) << lidx_q) : '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MENU;
            sel_q     <= '0;
            song_q    <= '0;
            lidx_q    <= '0;
            to_q      <= '0;
            written_q <= '0;
            for (int unsigned i = 0; i < KEY_BITS; i++) begin
                table_q[i]  <= KEY_BITS'(1) << i;
                backup_q[i] <= KEY_BITS'(1) << i;
            end
            div_q     <= '0;
            clock_q   <= '0;
            sub_q     <= 1'b0;
            sub_qq    <= 1'b0;
            can_q     <= 1'b0;
            can_qq    <= 1'b0;
            mapped_q  <= '0;
            buzzer_q  <= 1'b0;
            led_q     <= '0;
            seg_q     <= '0;
            t1_q      <= '0;
            t2_q      <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            song_q    <= song_d;
            lidx_q    <= lidx_d;
            to_q      <= to_d;
            written_q <= written_d;
            table_q   <= table_d;
            backup_q  <= backup_d;
            if (tick) begin
                div_q   <= '0;
                clock_q <= clock_q + CLOCK_BITS'(1);
            end else begin
                div_q   <= div_q + DIVW'(1);
            end
            sub_q     <= submit;
            sub_qq    <= sub_q;
            can_q     <= cancel;
            can_qq    <= can_q;
            mapped_q  <= mapped_d;
            buzzer_q  <= buzzer_d;
            led_q     <= led_d;
            seg_q     <= seg_d;
            t1_q      <= t1_d;
            t2_q      <= t2_d;
        end
    end

    assign mode_en      = (state_q == RUN) ? (N_MODES'(1) << sel_q) : '0;
    assign state        = state_q;
    assign song         = song_q;
    assign mapped_key   = mapped_q;
    assign system_clock = clock_q;
    assign buzzer       = buzzer_q;
    assign led          = led_q;
    assign seg_en       = seg_q;
    assign tube1        = t1_q;
    assign tube2        = t2_q;
    assign learn_idx    = lidx_q;

endmodule

// File: tb/tb_mode_dispatcher.sv
// Scoreboard bench for mode_dispatcher: stimulus pushes expected snapshots from a
// rule-level model; a monitor pops and compares them when a snapshot is presented.
module tb_mode_dispatcher;

    localparam int KB = 7, NM = 4, SB = 2, NS = 3, TB = 8, TD = 4, LT = 3, LIW = 3;
    localparam int S_MENU = 0, S_SS = 1, S_RUN = 2, S_LEARN = 3;

    logic clk = 1'b0, rst = 1'b1, submit = 1'b0, cancel = 1'b0;
    logic [KB-1:0]    note_key = '0;
    logic [NM-1:0]    needs_song = '0, mode_buzzer = '0;
    logic [NM*KB-1:0] mode_led = '0;
    logic [NM*TB-1:0] mode_seg_en = '0, mode_tube1 = '0, mode_tube2 = '0;
    logic [TB-1:0]    menu_seg_en = '0, menu_tube1 = '0, menu_tube2 = '0;
    logic [NM-1:0]    mode_en;
    logic [1:0]       state;
    logic [SB-1:0]    song;
    logic [KB-1:0]    mapped_key, led;
    logic             tick, buzzer;
    logic [31:0]      system_clock;
    logic [TB-1:0]    seg_en, tube1, tube2;
    logic [LIW-1:0]   learn_idx;

    always #5 clk = ~clk;

    mode_dispatcher #(
        .KEY_BITS(KB), .N_MODES(NM), .SONG_BITS(SB), .N_SONGS(NS), .TUBE_BITS(TB),
        .TICK_DIV(TD), .CLOCK_BITS(32), .LEARN_TIMEOUT(LT)
    ) dut (
        .clk(clk), .rst(rst), .submit(submit), .cancel(cancel), .note_key(note_key),
        .needs_song(needs_song), .mode_buzzer(mode_buzzer), .mode_led(mode_led),
        .mode_seg_en(mode_seg_en), .mode_tube1(mode_tube1), .mode_tube2(mode_tube2),
        .menu_seg_en(menu_seg_en), .menu_tube1(menu_tube1), .menu_tube2(menu_tube2),
        .mode_en(mode_en), .state(state), .song(song), .mapped_key(mapped_key),
        .tick(tick), .system_clock(system_clock), .buzzer(buzzer), .led(led),
        .seg_en(seg_en), .tube1(tube1), .tube2(tube2), .learn_idx(learn_idx)
    );

    typedef struct {
        logic [1:0]    st;
        logic [NM-1:0] en;
        logic [SB-1:0] song;
        logic [KB-1:0] mk;
        logic          buz;
        logic [KB-1:0] led;
        logic [TB-1:0] seg, t1, t2;
        logic [LIW-1:0] lidx;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0, errors = 0;
    bit   obs_valid = 1'b0;

    // Reference model: mode sequencing rules and the remap table as plain arrays.
    int            m_state, m_sel, m_song, m_lidx;
    logic [KB-1:0] m_table [KB];
    logic [KB-1:0] m_backup [KB];
    logic [KB-1:0] m_written;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_MENU; m_sel = 0; m_song = 0; m_lidx = 0; m_written = '0;
        for (int i = 0; i < KB; i++) begin
            m_table[i]  = KB'(1) << i;
            m_backup[i] = KB'(1) << i;
        end
    endtask

    task automatic model_step(input logic [KB-1:0] k, input bit s, input bit c);
        int idx;
        bit ok;
        ok  = ($countones(k) == 1);
        idx = 0;
        for (int i = 0; i < KB; i++) if (k[i]) idx = i;
        if (c && m_state != S_MENU) begin
            if (m_state == S_LEARN) m_table = m_backup;
            m_state = S_MENU;
            m_song  = 0;
            return;
        end
        if (c || !s || !ok) return;
        case (m_state)
            S_MENU: begin
                if (idx < NM) begin
                    m_sel   = idx;
                    m_state = needs_song[idx] ? S_SS : S_RUN;
                end else if (idx == NM) begin
                    m_backup  = m_table;
                    m_lidx    = 0;
                    m_written = '0;
                    m_state   = S_LEARN;
                end
            end
            S_SS: if (idx < NS) begin m_song = idx + 1; m_state = S_RUN; end
            S_LEARN: begin
                if (!m_written[idx]) begin
                    m_table[idx]   = KB'(1) << m_lidx;
                    m_written[idx] = 1'b1;
                    m_lidx++;
                    if (m_lidx == KB) m_state = S_MENU;
                end
            end
            default: ;
        endcase
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        e.st = 2'(m_state); e.song = SB'(m_song); e.lidx = LIW'(m_lidx);
        e.en = '0; e.mk = '0; e.buz = 1'b0; e.led = '0;
        e.seg = menu_seg_en; e.t1 = menu_tube1; e.t2 = menu_tube2;
        if (m_state == S_SS || m_state == S_RUN)
            for (int i = 0; i < KB; i++) if (note_key[i]) e.mk = e.mk | m_table[i];
        if (m_state == S_RUN) begin
            e.en  = NM'(1) << m_sel;
            e.buz = mode_buzzer[m_sel];
            e.led = mode_led[m_sel*KB +: KB];
            e.seg = mode_seg_en[m_sel*TB +: TB];
            e.t1  = mode_tube1[m_sel*TB +: TB];
            e.t2  = mode_tube2[m_sel*TB +: TB];
        end else if (m_state == S_SS) begin
            e.led = KB'(1) << m_sel;
        end else if (m_state == S_LEARN) begin
            e.led = (m_lidx < KB) ? (KB'(1) << m_lidx) : '0;
        end
        return e;
    endfunction

    // Monitor: compares each presented snapshot against the oldest expectation.
    initial forever begin
        @(negedge clk);
        if (obs_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("state", state, e.st);
                chk("mode_en", mode_en, e.en);
                chk("song", song, e.song);
                chk("mapped_key", mapped_key, e.mk);
                chk("buzzer", buzzer, e.buz);
                chk("led", led, e.led);
                chk("seg_en", seg_en, e.seg);
                chk("tube1", tube1, e.t1);
                chk("tube2", tube2, e.t2);
                chk("learn_idx", learn_idx, e.lidx);
            end
        end
    end

    // Tick checker: n cycles after the last reset edge, tick marks n%TD==TD-1.
    initial begin
        int n;
        bit r;
        n = 0;
        forever begin
            @(posedge clk);
            r = rst;
            @(negedge clk);
            n = r ? 0 : n + 1;
            if (n < 64) begin
                chk("tick", tick, ((n % TD) == TD - 1) ? 32'd1 : 32'd0);
                chk("system_clock", system_clock, 32'(n / TD));
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic observe();
        @(posedge clk);
        #1;
        sb_q.push_back(expect_now());
        obs_valid = 1'b1;
        @(posedge clk);
        #1 obs_valid = 1'b0;
    endtask

    task automatic press(input logic [KB-1:0] k, input bit s, input bit c);
        note_key = k; submit = s; cancel = c;
        @(posedge clk);
        #1 submit = 1'b0; cancel = 1'b0;
        @(posedge clk);
        model_step(k, s, c);
        observe();
    endtask

    task automatic hold(input logic [KB-1:0] k);
        note_key = k; submit = 1'b1;
        repeat (10) @(posedge clk);
        #1 submit = 1'b0;
        @(posedge clk);
        model_step(k, 1'b1, 1'b0);
        observe();
    endtask

    task automatic idle_timeout(input int cycles);
        note_key = '0;
        repeat (cycles) @(posedge clk);
        if (m_state == S_LEARN) begin
            m_table = m_backup;
            m_state = S_MENU;
        end
        observe();
    endtask

    task automatic reset_dut();
        exp_t e;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        e.st = '0; e.en = '0; e.song = '0; e.mk = '0; e.buz = 1'b0; e.led = '0;
        e.seg = '0; e.t1 = '0; e.t2 = '0; e.lidx = '0;
        sb_q.push_back(e);
        obs_valid = 1'b1;
        @(posedge clk);
        #1 obs_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic randomize_inputs();
        mode_buzzer = NM'($urandom);
        mode_led    = (NM*KB)'($urandom);
        mode_seg_en = $urandom; mode_tube1 = $urandom; mode_tube2 = $urandom;
        menu_seg_en = TB'($urandom); menu_tube1 = TB'($urandom); menu_tube2 = TB'($urandom);
    endtask

    task automatic learn_session();
        int perm[KB];
        int dup_at, abort_at, j2, tmp;
        logic [KB-1:0] oh;
        for (int i = 0; i < KB; i++) perm[i] = i;
        for (int i = KB - 1; i > 0; i--) begin
            j2 = $urandom_range(0, i);
            tmp = perm[i]; perm[i] = perm[j2]; perm[j2] = tmp;
        end
        dup_at   = $urandom_range(1, KB - 1);
        abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, KB - 1) : -1;
        for (int j = 0; j < KB; j++) begin
            if (j == abort_at) begin
                oh = KB'(1) << $urandom_range(0, KB - 1);
                press(oh, 1'b1, 1'b1);
                return;
            end
            if (j == dup_at) press(KB'(1) << perm[$urandom_range(0, j - 1)], 1'b1, 1'b0);
            press(KB'(1) << perm[j], 1'b1, 1'b0);
        end
    endtask

    initial begin
        logic [KB-1:0] k;
        randomize_inputs();
        needs_song = 4'b0010;
        reset_dut();

        // Song-select path into RUN, then simultaneous cancel+submit.
        press(7'b0000010, 1'b1, 1'b0);
        press(7'b0000100, 1'b1, 1'b0);
        press(7'b0000001, 1'b1, 1'b1);
        // Invalid keys in MENU.
        press(7'b0000011, 1'b1, 1'b0);
        press(7'b0000000, 1'b1, 1'b0);
        press(7'b1000000, 1'b1, 1'b0);

        // Reverse-order learn with a duplicate, then probe the remap in RUN.
        press(7'b0010000, 1'b1, 1'b0);
        for (int p = KB - 1; p >= 0; p--) begin
            press(KB'(1) << p, 1'b1, 1'b0);
            if (p == 4) press(7'b0100000, 1'b1, 1'b0);
        end
        needs_song = 4'b0000;
        press(7'b0001000, 1'b1, 1'b0);
        press(7'b1000000, 1'b0, 1'b0);
        press(7'b0000001, 1'b0, 1'b0);
        press(7'b0000001, 1'b0, 1'b1);

        // Timeout abort restores the pre-session (identity) table.
        reset_dut();
        press(7'b0010000, 1'b1, 1'b0);
        press(7'b0000100, 1'b1, 1'b0);
        press(7'b0000001, 1'b1, 1'b0);
        idle_timeout(20);
        press(7'b0001000, 1'b1, 1'b0);
        press(7'b0000001, 1'b0, 1'b0);
        press(7'b0000101, 1'b0, 1'b0);
        press(7'b0000000, 1'b0, 1'b1);

        // Reset mid-session.
        press(7'b0010000, 1'b1, 1'b0);
        press(7'b0100000, 1'b1, 1'b0);
        press(7'b0000010, 1'b1, 1'b0);
        reset_dut();
        press(7'b0000100, 1'b1, 1'b0);
        press(7'b0100010, 1'b0, 1'b0);
        press(7'b0000000, 1'b0, 1'b1);

        // Held submit yields one pulse per press.
        needs_song = 4'b0001;
        hold(7'b0000001);
        hold(7'b0000001);
        press(7'b0000000, 1'b0, 1'b1);

        for (int it = 0; it < 150; it++) begin
            randomize_inputs();
            needs_song = NM'($urandom);
            case (m_state)
                S_MENU: begin
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3, 4, 5: k = KB'(1) << $urandom_range(0, NM - 1);
                        6:       k = KB'(1) << NM;
                        7:       k = KB'(1) << $urandom_range(NM + 1, KB - 1);
                        default: k = KB'($urandom);
                    endcase
                    press(k, 1'b1, $urandom_range(0, 9) == 0);
                end
                S_SS: begin
                    k = ($urandom_range(0, 3) == 0) ? KB'($urandom) : KB'(1) << $urandom_range(0, KB - 1);
                    press(k, 1'b1, $urandom_range(0, 6) == 0);
                end
                S_RUN: press(KB'($urandom), 1'($urandom), $urandom_range(0, 4) == 0);
                default: learn_session();
            endcase
        end

        repeat (3) @(posedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
